// File: rtl/ice_bus_pkg.sv
// Shared definitions for the ICE slave output bus: frame-transmitter states,
// the valid-bit position of the 9-bit sl_* beats, and the tail status codes.
package ice_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT_ARB,
    ST_ADDR,
    ST_DATA,
    ST_TAIL
  } state_e;

  localparam int         SL_VALID_BIT = 8;
  localparam logic [7:0] TAIL_OK      = 8'h00;
  localparam logic [7:0] TAIL_ERR     = 8'h01;

  // Builds one bus beat with the valid bit set above the byte.
  function automatic logic [8:0] sl_beat(input logic [7:0] v);
    logic [8:0] b;
    b               = '0;
    b[SL_VALID_BIT] = 1'b1;
    b[7:0]          = v;
    return b;
  endfunction

endpackage

// File: rtl/ice_sync_fifo.sv
// Single-clock byte FIFO with AW+1 bit pointers, synchronous clear and
// show-ahead read (dout is the head entry while the FIFO is non-empty).
module ice_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic       last,
  output logic [7:0] dout
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic [AW:0] fill;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q[AW-1:0]] <= din;
  end

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign fill  = wr_q - rd_q;
  assign last  = (fill == {{AW{1'b0}}, 1'b1});
  assign dout  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/ice_slave_frame_tx.sv
// Store-and-forward frame transmitter for the ICE slave bus (sl_*).
// Define ICE_FRAME_TX_TIMESTAMP_EN to prepend a global_counter timestamp beat.
module ice_slave_frame_tx
  import ice_bus_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic       clk,
  input  logic       reset,
`ifdef ICE_FRAME_TX_TIMESTAMP_EN
  input  logic [7:0] global_counter,
`endif
  input  logic       frm_start,
  input  logic [7:0] frm_type,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       frm_commit,
  input  logic [7:0] frm_tail,
  output logic       busy,
  output logic       full,
  output logic       drop,
  output logic       sent,
  output logic       sl_arb_request,
  input  logic       sl_arb_grant,
  input  logic       sl_overflow,
  output logic [8:0] sl_addr,
  output logic [8:0] sl_data,
  output logic [8:0] sl_tail,
  output logic       sl_latch_tail
);

  state_e     state_q;
  logic       ovf_q;
  logic       drop_q;
  logic [7:0] type_q;
  logic [7:0] tail_q;
  logic       ts_pend;

  logic       fifo_clr;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_last;
  logic [7:0] fifo_dout;
  logic       start_ok;
  logic       commit_ok;
  logic       ovf_now;
  logic [7:0] beat_byte;

  assign start_ok  = (state_q == ST_IDLE) && frm_start;
  assign commit_ok = (state_q == ST_FILL) && frm_commit;
  // A byte rejected in the commit cycle still poisons the frame.
  assign ovf_now   = ovf_q || (wr_en && fifo_full);

  assign fifo_clr  = start_ok;
  assign fifo_push = (state_q == ST_FILL) && wr_en && !fifo_full;
  assign fifo_pop  = (state_q == ST_DATA) && !sl_overflow && !ts_pend;

  ice_sync_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clr  (fifo_clr),
    .push (fifo_push),
    .din  (wr_data),
    .pop  (fifo_pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .last (fifo_last),
    .dout (fifo_dout)
  );

`ifdef ICE_FRAME_TX_TIMESTAMP_EN
  logic       ts_pend_q;
  logic [7:0] ts_q;

  assign ts_pend   = ts_pend_q;
  assign beat_byte = ts_pend_q ? ts_q : fifo_dout;

  always_ff @(posedge clk) begin
    if (start_ok) ts_q <= global_counter;
  end
`else
  assign ts_pend   = 1'b0;
  assign beat_byte = fifo_dout;
`endif

  always_ff @(posedge clk) begin
    if (start_ok)  type_q <= frm_type;
    if (commit_ok) tail_q <= frm_tail;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
`ifdef ICE_FRAME_TX_TIMESTAMP_EN
      ts_pend_q <= 1'b0;
`endif
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frm_start) begin
            ovf_q   <= 1'b0;
            state_q <= ST_FILL;
`ifdef ICE_FRAME_TX_TIMESTAMP_EN
            ts_pend_q <= 1'b1;
`endif
          end
        end
        ST_FILL: begin
          if (wr_en && fifo_full) ovf_q <= 1'b1;
          if (frm_commit) begin
            if (ovf_now) begin
              drop_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_ARB;
            end
          end
        end
        ST_WAIT_ARB: begin
          if (sl_arb_grant) state_q <= ST_ADDR;
        end
        ST_ADDR: begin
          state_q <= (fifo_empty && !ts_pend) ? ST_TAIL : ST_DATA;
        end
        ST_DATA: begin
          if (!sl_overflow) begin
`ifdef ICE_FRAME_TX_TIMESTAMP_EN
            if (ts_pend_q) begin
              ts_pend_q <= 1'b0;
              if (fifo_empty) state_q <= ST_TAIL;
            end else
`endif
            if (fifo_last) state_q <= ST_TAIL;
          end
        end
        ST_TAIL: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs decode only the registered state, so they are zero outside
  // ADDR/DATA/TAIL and collapse immediately with the async reset.
  assign busy           = (state_q != ST_IDLE);
  assign full           = fifo_full;
  assign drop           = drop_q;
  assign sent           = (state_q == ST_TAIL);
  assign sl_arb_request = (state_q == ST_WAIT_ARB) || (state_q == ST_ADDR) ||
                          (state_q == ST_DATA) || (state_q == ST_TAIL);
  assign sl_addr        = (state_q == ST_ADDR) ? sl_beat(type_q) : 9'h000;
  assign sl_data        = ((state_q == ST_DATA) && !sl_overflow) ? sl_beat(beat_byte) : 9'h000;
  assign sl_tail        = (state_q == ST_TAIL) ? sl_beat(tail_q) : 9'h000;
  assign sl_latch_tail  = (state_q == ST_TAIL);

endmodule

// File: doc/ice_slave_frame_tx.md
Name: ice_slave_frame_tx

Overview:
- Reusable store-and-forward transmitter for the ICE slave output bus (sl_*), used inside peripheral interfaces such as gpio/pmu/ein.
- A client builds one frame: a message type, N payload bytes and a tail status code.
- The block buffers the frame, arbitrates for the shared slave bus, then emits the frame toward the bus controller, which serializes it to UART.
- It is the transmitting end of the bus whose receiving end is the bus controller.

Parameters:
- DEPTH, 64, payload FIFO depth in bytes; power of two; max frame payload.
- AW, 6, FIFO address width; log2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- frm_start  in  1  begin new frame; accepted only in IDLE.
- frm_type  in  8  message type; sampled with accepted frm_start.
- wr_en  in  1  push payload byte; honoured only in FILL.
- wr_data  in  8  payload byte.
- frm_commit  in  1  close frame; honoured only in FILL.
- frm_tail  in  8  tail status code; sampled with frm_commit.
- busy  out  1  high in every state except IDLE.
- full  out  1  FIFO holds DEPTH bytes.
- drop  out  1  one-cycle pulse: frame discarded due to overflow.
- sent  out  1  one-cycle pulse: tail emitted.
- sl_arb_request  out  1  slave bus request.
- sl_arb_grant  in  1  slave bus grant.
- sl_overflow  in  1  controller cannot accept data; stall.
- sl_addr  out  9  {valid, type}.
- sl_data  out  9  {valid, byte}.
- sl_tail  out  9  {valid, code}.
- sl_latch_tail  out  1  tail strobe.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE. Reset mid-frame drops the request immediately (async) and discards the frame silently; no drop or sent pulse.
- Shared-bus rule: sl_addr, sl_data, sl_tail and sl_latch_tail are 0 whenever the state is not ADDR/DATA/TAIL. The bus is OR-combined across slaves.
- IDLE: frm_start → latch type, clear FIFO and ovf flag, go to FILL.
- FILL:
  - wr_en with FIFO not full pushes the byte.
  - wr_en with FIFO full discards the byte and sets ovf.
  - wr_en and frm_commit in the same cycle: the byte is pushed first and is part of the frame.
  - frm_commit with ovf set → drop pulse, go to IDLE.
  - frm_commit with ovf clear → latch tail, go to WAIT_ARB.
  - frm_start in FILL is ignored.
- WAIT_ARB: sl_arb_request=1, held until grant. The arbiter contract is that grant, once given, holds while request stays high; the block does not re-check grant mid-frame.
- ADDR: exactly one cycle after grant seen, sl_addr={1,type}. Next state is DATA if the FIFO is non-empty, else TAIL (zero-length frame is legal).
- DATA:
  - Each cycle with sl_overflow=0: sl_data={1,head byte}, pop.
  - Each cycle with sl_overflow=1: sl_data=0, no pop.
  - After the last pop, go to TAIL.
  - Throughput: 1 byte/cycle.
- TAIL: one cycle, sl_tail={1,tail}, sl_latch_tail=1, sent=1. Next cycle: IDLE, sl_arb_request=0.
- Request is high from WAIT_ARB through TAIL inclusive.
- Latency: grant → ADDR beat = 1 cycle. N-byte frame with no stalls occupies N+2 cycles after grant.
- Inputs arriving outside the legal state (wr_en/frm_commit outside FILL, frm_start outside IDLE) are ignored; no error.
- FIFO pointers are AW+1 bits; full/empty use an MSB compare; wrap-around is natural.

Optional Feature:
- Macro: ICE_FRAME_TX_TIMESTAMP_EN.
- When defined, adds input global_counter[7:0]. Its value is captured on the accepted frm_start and emitted as the first DATA beat ahead of the payload.
- With the macro, effective payload capacity stays DEPTH; the timestamp is held in a register, not the FIFO.
- When undefined, the port is absent and frames carry the payload only.

Decomposition:
- ice_bus_pkg holds:
  - state encoding (IDLE, FILL, WAIT_ARB, ADDR, DATA, TAIL);
  - SL_VALID_BIT=8;
  - tail codes TAIL_OK=8'h00, TAIL_ERR=8'h01.
- Natural sub-module ice_sync_fifo (DEPTH/AW parameters; push/pop/full/empty/dout). The control FSM stays in the top.

Test Plan:
- Start type=8'h67, push 8'hA1,8'hB2,8'hC3, commit tail=8'h00; grant 2 cycles after request → sl_addr=9'h167, then data 9'h1A1,9'h1B2,9'h1C3 on consecutive cycles, then sl_tail=9'h100 with sl_latch_tail and sent; request drops the next cycle.
- Zero-length frame type=8'h50, commit tail=8'h01 → ADDR 9'h150 then TAIL 9'h101; no sl_data beat.
- DEPTH=64: push 65 bytes then commit → drop pulse, request never asserted, busy low the next cycle.
- 4-byte frame, hold sl_overflow=1 for 3 cycles after the second data beat → data stalls at 0 for exactly 3 cycles, remaining bytes in order, all 4 delivered.
- Assert reset during DATA after 2 of 5 beats → all outputs 0 at once, no sent pulse; a following new frame transmits correctly.
- With ICE_FRAME_TX_TIMESTAMP_EN, global_counter=8'h3C at start, payload 8'h11 → data beats 9'h13C then 9'h111.
